id_ex_operand_stage: RTL and testbench

- Registered decode-to-execute stage. It sits directly upstream of ALU_32bit and drives its Src1, Src2 and ALU_Control inputs.
- Resolves operands from register-file data, the sign-extended immediate, and EX/MEM and MEM/WB forwarding results.
- Holds the issued operation under valid/ready backpressure and keeps one skid entry, so In_Ready is purely registered.
- Supports pipeline flush and counts downstream stall cycles.

---
 rtl/id_ex_operand_stage.sv | 94 +++++++++
 tb/tb_id_ex_operand_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: registered ID/EX operand resolution with forwarding, skid buffer, flush and stall counting
module id_ex_operand_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [WIDTH-1:0]      Rs_Data,
  input  logic [WIDTH-1:0]      Rt_Data,
  input  logic [WIDTH-1:0]      Imm,
  input  logic [REG_ADDR_W-1:0] Rs_Addr,
  input  logic [REG_ADDR_W-1:0] Rt_Addr,
  input  logic [REG_ADDR_W-1:0] Rd_Addr,
  input  logic                  ALU_Src,
  input  logic [2:0]            ALU_Control_In,
  input  logic                  Reg_Write_In,
  input  logic                  ExMem_Reg_Write,
  input  logic [REG_ADDR_W-1:0] ExMem_Rd,
  input  logic [WIDTH-1:0]      ExMem_Result,
  input  logic                  MemWb_Reg_Write,
  input  logic [REG_ADDR_W-1:0] MemWb_Rd,
  input  logic [WIDTH-1:0]      MemWb_Result,
  input  logic                  Flush,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [WIDTH-1:0]      Src1,
  output logic [WIDTH-1:0]      Src2,
  output logic [2:0]            ALU_Control,
  output logic [REG_ADDR_W-1:0] Rd_Out,
  output logic                  Reg_Write_Out,
  output logic [CNT_W-1:0]      Stall_Count
);
  typedef struct packed {
    logic [WIDTH-1:0]      src1;
    logic [WIDTH-1:0]      src2;
    logic [2:0]            ctl;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rw;
  } entry_t;
  entry_t main_q, main_d, skid_q, skid_d, in_e;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [WIDTH-1:0] fwd_rs, fwd_rt;
  logic accept, main_load;
  // EX/MEM is the younger producer, so it wins over MEM/WB; register 0 is hardwired zero
  assign fwd_rs = (Rs_Addr == '0) ? '0 :
                  (ExMem_Reg_Write && ExMem_Rd == Rs_Addr) ? ExMem_Result :
                  (MemWb_Reg_Write && MemWb_Rd == Rs_Addr) ? MemWb_Result : Rs_Data;
  assign fwd_rt = (Rt_Addr == '0) ? '0 :
                  (ExMem_Reg_Write && ExMem_Rd == Rt_Addr) ? ExMem_Result :
                  (MemWb_Reg_Write && MemWb_Rd == Rt_Addr) ? MemWb_Result : Rt_Data;
  assign in_e      = {fwd_rs, ALU_Src ? Imm : fwd_rt, ALU_Control_In, Rd_Addr, Reg_Write_In};
  assign In_Ready  = ~skid_valid_q;
  assign accept    = In_Valid & ~skid_valid_q;
  assign main_load = ~out_valid_q | Out_Ready;
  always_comb begin
    out_valid_d  = main_load ? (skid_valid_q | accept) : out_valid_q;
    main_d       = main_load ? (skid_valid_q ? skid_q : (accept ? in_e : main_q)) : main_q;
    skid_valid_d = main_load ? 1'b0 : (skid_valid_q | accept);
    skid_d       = (~main_load & accept) ? in_e : skid_q;
    stall_d      = (out_valid_q & ~Out_Ready & ~&stall_q) ? stall_q + 1'b1 : stall_q;
    if (Flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      main_d.rw    = 1'b0;
      skid_d.rw    = 1'b0;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      stall_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      stall_q      <= stall_d;
    end
  end
  assign Out_Valid     = out_valid_q;
  assign Src1          = main_q.src1;
  assign Src2          = main_q.src2;
  assign ALU_Control   = main_q.ctl;
  assign Rd_Out        = main_q.rd;
  assign Reg_Write_Out = out_valid_q & main_q.rw;
  assign Stall_Count   = stall_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: random and directed checks against a queue-based reference model
module tb_id_ex_operand_stage;
  localparam int CW = 4;
  logic CLK = 1'b0, RST;
  logic In_Valid, In_Ready, ALU_Src, Reg_Write_In, ExMem_Reg_Write, MemWb_Reg_Write, Flush;
  logic Out_Valid, Out_Ready, Reg_Write_Out;
  logic [31:0] Rs_Data, Rt_Data, Imm, ExMem_Result, MemWb_Result, Src1, Src2;
  logic [4:0] Rs_Addr, Rt_Addr, Rd_Addr, ExMem_Rd, MemWb_Rd, Rd_Out;
  logic [2:0] ALU_Control_In, ALU_Control;
  logic [CW-1:0] Stall_Count;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    logic [31:0] s1, s2;
    logic [2:0]  ctl;
    logic [4:0]  rd;
    logic        rw;
  } op_t;
  op_t q[$];
  int stall_m = 0;

  id_ex_operand_stage #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Rs_Data(Rs_Data), .Rt_Data(Rt_Data), .Imm(Imm), .Rs_Addr(Rs_Addr), .Rt_Addr(Rt_Addr),
    .Rd_Addr(Rd_Addr), .ALU_Src(ALU_Src), .ALU_Control_In(ALU_Control_In), .Reg_Write_In(Reg_Write_In),
    .ExMem_Reg_Write(ExMem_Reg_Write), .ExMem_Rd(ExMem_Rd), .ExMem_Result(ExMem_Result),
    .MemWb_Reg_Write(MemWb_Reg_Write), .MemWb_Rd(MemWb_Rd), .MemWb_Result(MemWb_Result),
    .Flush(Flush), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Src1(Src1), .Src2(Src2),
    .ALU_Control(ALU_Control), .Rd_Out(Rd_Out), .Reg_Write_Out(Reg_Write_Out), .Stall_Count(Stall_Count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] d);
    if (a == 0) return 32'd0;
    if (ExMem_Reg_Write && ExMem_Rd == a) return ExMem_Result;
    if (MemWb_Reg_Write && MemWb_Rd == a) return MemWb_Result;
    return d;
  endfunction

  task automatic idle();
    In_Valid = 0; Out_Ready = 1; Flush = 0; ALU_Src = 0; Reg_Write_In = 0;
    Rs_Data = 0; Rt_Data = 0; Imm = 0; Rs_Addr = 0; Rt_Addr = 0; Rd_Addr = 0;
    ALU_Control_In = 0; ExMem_Reg_Write = 0; ExMem_Rd = 0; ExMem_Result = 0;
    MemWb_Reg_Write = 0; MemWb_Rd = 0; MemWb_Result = 0;
  endtask

  task automatic compare_outputs();
    check("out_valid", Out_Valid, q.size() > 0);
    check("reg_write_out", Reg_Write_Out, q.size() > 0 ? q[0].rw : 1'b0);
    check("stall_count", Stall_Count, stall_m);
    if (q.size() > 0) begin
      check("src1", Src1, q[0].s1);
      check("src2", Src2, q[0].s2);
      check("alu_control", ALU_Control, q[0].ctl);
      check("rd_out", Rd_Out, q[0].rd);
    end
  endtask

  // one clock: model the edge from the currently driven inputs, then compare
  task automatic step();
    op_t o;
    int sz;
    sz = q.size();
    check("in_ready", In_Ready, sz < 2);
    o.s1 = resolve(Rs_Addr, Rs_Data);
    o.s2 = ALU_Src ? Imm : resolve(Rt_Addr, Rt_Data);
    o.ctl = ALU_Control_In; o.rd = Rd_Addr; o.rw = Reg_Write_In;
    if (sz > 0 && !Out_Ready && stall_m < 2**CW - 1) stall_m++;
    if (sz > 0 && Out_Ready) void'(q.pop_front());
    if (In_Valid && sz < 2) q.push_back(o);
    if (Flush) q.delete();
    @(posedge CLK); #1;
    compare_outputs();
  endtask

  task automatic send(input logic [4:0] rs, input logic [31:0] rsd, input logic [2:0] ctl);
    In_Valid = 1; Rs_Addr = rs; Rs_Data = rsd; ALU_Control_In = ctl; Rd_Addr = rs + 5'd1; Reg_Write_In = 1;
    step();
  endtask

  initial begin
    idle();
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", Out_Valid, 0);
    check("rst_in_ready", In_Ready, 1);
    check("rst_src1", Src1, 0);
    check("rst_src2", Src2, 0);
    check("rst_ctl", ALU_Control, 0);
    check("rst_rd", Rd_Out, 0);
    check("rst_rw", Reg_Write_Out, 0);
    check("rst_stall", Stall_Count, 0);
    RST = 0;
    // forwarding priority: EX/MEM over MEM/WB
    In_Valid = 1; Rs_Addr = 3; Rs_Data = 1; ExMem_Reg_Write = 1; ExMem_Rd = 3; ExMem_Result = 25;
    MemWb_Reg_Write = 1; MemWb_Rd = 3; MemWb_Result = 7; ALU_Control_In = 3'b010; Rt_Addr = 4; Rt_Data = 15;
    step();
    check("fwd_exmem_src1", Src1, 25);
    check("fwd_src2", Src2, 15);
    check("fwd_ctl", ALU_Control, 3'b010);
    check("alu_sum", Src1 + Src2, 40);
    idle();
    In_Valid = 1; Rs_Addr = 0; Rs_Data = 5; ExMem_Reg_Write = 1; ExMem_Rd = 0; ExMem_Result = 99;
    Rt_Addr = 6; Rt_Data = 3; MemWb_Reg_Write = 1; MemWb_Rd = 6; MemWb_Result = 10;
    step();
    check("r0_src1", Src1, 0);
    check("fwd_memwb_src2", Src2, 10);
    idle();
    In_Valid = 1; ALU_Src = 1; Imm = 32'hFFFFFFFE; Rt_Addr = 2; Rt_Data = 9;
    step();
    check("imm_src2", Src2, 32'hFFFFFFFE);
    // backpressure: A held, B in skid, C refused until both drain
    idle(); step();
    Out_Ready = 0;
    send(1, 10, 3'b100);
    send(2, 20, 3'b010);
    check("skid_in_ready", In_Ready, 0);
    send(3, 30, 3'b001);
    send(3, 30, 3'b001);
    check("held_a", Src1, 10);
    check("stall3", Stall_Count, 3);
    Out_Ready = 1;
    step();
    check("deliver_b", Src1, 20);
    step();
    check("deliver_c", Src1, 30);
    In_Valid = 0;
    step();
    // flush with two entries held and an input offered
    Out_Ready = 0;
    send(1, 11, 3'b000);
    send(2, 22, 3'b000);
    Flush = 1;
    send(3, 33, 3'b000);
    check("flush_valid", Out_Valid, 0);
    check("flush_rw", Reg_Write_Out, 0);
    check("flush_in_ready", In_Ready, 1);
    Flush = 0; In_Valid = 0; Out_Ready = 1;
    step();
    check("flush_nothing", Out_Valid, 0);
    // asynchronous reset with two entries held
    Out_Ready = 0;
    send(1, 44, 3'b101);
    send(2, 55, 3'b110);
    step();
    RST = 1; #2;
    check("arst_valid", Out_Valid, 0);
    check("arst_in_ready", In_Ready, 1);
    check("arst_stall", Stall_Count, 0);
    q.delete(); stall_m = 0;
    RST = 0; #1;
    Out_Ready = 1;
    send(4, 66, 3'b010);
    check("post_rst_accept", Src1, 66);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      In_Valid = $urandom_range(0, 3) != 0;
      Out_Ready = $urandom_range(0, 2) != 0;
      Flush = $urandom_range(0, 15) == 0;
      Rs_Addr = 5'($urandom_range(0, 3)); Rt_Addr = 5'($urandom_range(0, 3)); Rd_Addr = 5'($urandom);
      ExMem_Rd = 5'($urandom_range(0, 3)); MemWb_Rd = 5'($urandom_range(0, 3));
      ExMem_Reg_Write = 1'($urandom); MemWb_Reg_Write = 1'($urandom);
      Rs_Data = $urandom; Rt_Data = $urandom; Imm = $urandom;
      ExMem_Result = $urandom; MemWb_Result = $urandom;
      ALU_Src = 1'($urandom); Reg_Write_In = 1'($urandom); ALU_Control_In = 3'($urandom);
      step();
    end
    // saturation of the stall counter
    idle(); step();
    Out_Ready = 0;
    send(1, 7, 3'b000);
    In_Valid = 0;
    repeat (20) step();
    check("stall_sat", Stall_Count, 2**CW - 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
